bcd_display_scan: RTL and testbench

//   Sequences a 4-digit multiplexed 7-segment display from a binary value. Captures a value on a

---
 rtl/bcd_display_scan.sv | 158 +++++++++++++++
 tb/tb_bcd_display_scan.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_scan.sv
// 4-digit multiplexed 7-segment scanner: accepts a binary value on valid/ready,
// converts it to BCD and strobes the digits with leading-zero blanking.

// Combinational binary-to-BCD (shift-and-add-3) plus count of significant digits.
module bin2bcd_int #(
   parameter int WIDTH = 15,
   parameter int ND    = ((WIDTH * 3) / 10 + 1 < 4) ? 4 : (WIDTH * 3) / 10 + 1,
   parameter int DW    = $clog2(ND + 1)
) (
   input  logic [WIDTH-1:0]  bin,
   output logic [4*ND-1:0]   bcd,
   output logic [DW-1:0]     int_digits
);
   logic [4*ND+WIDTH-1:0] sh;

   always_comb begin
      sh = '0;
      sh[WIDTH-1:0] = bin;
      for (int i = 0; i < WIDTH; i++) begin
         for (int d = 0; d < ND; d++)
            if (sh[WIDTH+4*d +: 4] >= 4'd5)
               sh[WIDTH+4*d +: 4] = sh[WIDTH+4*d +: 4] + 4'd3;
         sh = sh << 1;
      end
      bcd = sh[WIDTH +: 4*ND];
      // Zero still counts as one digit so the ones place is always shown.
      int_digits = DW'(1);
      for (int d = 1; d < ND; d++)
         if (bcd[4*d +: 4] != 4'd0)
            int_digits = DW'(d + 1);
   end
endmodule

module bcd_display_scan #(
   parameter int WIDTH       = 15,
   parameter int REFRESH_DIV = 50000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] bin,
   output logic [3:0]       an,
   output logic [6:0]       seg,
   output logic             dp,
   output logic             ovf
);
   localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam int ND = ((WIDTH * 3) / 10 + 1 < 4) ? 4 : (WIDTH * 3) / 10 + 1;
   localparam int DW = $clog2(ND + 1);
   localparam int unsigned MAXV = 9999;

   typedef enum logic [1:0] {IDLE, LOAD, SCAN} state_t;

   state_t           state;
   logic [WIDTH-1:0] bin_q;
   logic [15:0]      dig_q;
   logic [2:0]       cnt_q;
   logic [1:0]       idx;
   logic [RW-1:0]    rcnt;
   logic             act;
   logic [4*ND-1:0]  bcd;
   logic [DW-1:0]    nd;
   logic             xfer;

   bin2bcd_int #(.WIDTH(WIDTH)) u_b2b (
      .bin        (bin_q),
      .bcd        (bcd),
      .int_digits (nd)
   );

   function automatic logic [6:0] dec7(input logic [3:0] d);
      case (d)
         4'd0:    dec7 = 7'h40;
         4'd1:    dec7 = 7'h79;
         4'd2:    dec7 = 7'h24;
         4'd3:    dec7 = 7'h30;
         4'd4:    dec7 = 7'h19;
         4'd5:    dec7 = 7'h12;
         4'd6:    dec7 = 7'h02;
         4'd7:    dec7 = 7'h78;
         4'd8:    dec7 = 7'h00;
         4'd9:    dec7 = 7'h10;
         default: dec7 = 7'h7F;
      endcase
   endfunction

   assign xfer = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         in_ready <= 1'b1;
         bin_q    <= '0;
         dig_q    <= '0;
         cnt_q    <= '0;
         idx      <= '0;
         rcnt     <= '0;
         act      <= 1'b0;
         ovf      <= 1'b0;
         an       <= 4'b1111;
         seg      <= 7'h7F;
         dp       <= 1'b1;
      end else begin
         dp <= 1'b1;
         // Drive lags index/data by one cycle, so a LOAD keeps the old value lit.
         if (!act) begin
            an  <= 4'b1111;
            seg <= 7'h7F;
         end else begin
            an  <= ~(4'b0001 << idx);
            seg <= ({1'b0, idx} < cnt_q) ? dec7(dig_q[4*idx +: 4]) : 7'h7F;
         end

         case (state)
            IDLE: begin
               if (xfer) begin
                  bin_q    <= bin;
                  in_ready <= 1'b0;
                  state    <= LOAD;
               end
            end
            LOAD: begin
               if (32'(bin_q) > MAXV) begin
                  dig_q <= 16'h9999;
                  cnt_q <= 3'd4;
                  ovf   <= 1'b1;
               end else begin
                  dig_q <= bcd[15:0];
                  cnt_q <= nd[2:0];
                  ovf   <= 1'b0;
               end
               rcnt     <= '0;
               idx      <= '0;
               act      <= 1'b1;
               in_ready <= 1'b1;
               state    <= SCAN;
            end
            SCAN: begin
               if (xfer) begin
                  bin_q    <= bin;
                  in_ready <= 1'b0;
                  state    <= LOAD;
               end else if (rcnt == RW'(REFRESH_DIV - 1)) begin
                  rcnt <= '0;
                  idx  <= idx + 2'd1;
               end else begin
                  rcnt <= rcnt + RW'(1);
               end
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_bcd_display_scan.sv
// Randomized scoreboard bench for bcd_display_scan with a decimal reference model.
module tb_bcd_display_scan;
   localparam int WIDTH = 15;
   localparam int DIV   = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] bin;
   logic [3:0]       an;
   logic [6:0]       seg;
   logic             dp;
   logic             ovf;

   bcd_display_scan #(.WIDTH(WIDTH), .REFRESH_DIV(DIV)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .bin      (bin),
      .an       (an),
      .seg      (seg),
      .dp       (dp),
      .ovf      (ovf)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0][6:0] seg;
      logic            ovf;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
      end
   endtask

   function automatic exp_t model(input int unsigned v);
      logic [6:0] tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
      int unsigned pw [4] = '{1, 10, 100, 1000};
      int unsigned d [4];
      int n;
      exp_t e;
      if (v > 9999) begin
         for (int i = 0; i < 4; i++) d[i] = 9;
         n = 4;
         e.ovf = 1'b1;
      end else begin
         for (int i = 0; i < 4; i++) d[i] = (v / pw[i]) % 10;
         n = (v >= 1000) ? 4 : (v >= 100) ? 3 : (v >= 10) ? 2 : 1;
         e.ovf = 1'b0;
      end
      for (int i = 0; i < 4; i++) e.seg[i] = (i < n) ? tab[d[i]] : 7'h7F;
      return e;
   endfunction

   // Monitor: in_ready low marks a LOAD; the new value is lit two samples later.
   exp_t cur, pend;
   bit   active = 0;
   int   pend_cnt = 0;
   int   k = 0;
   bit   prev_nr = 0;

   always @(negedge clk) begin
      logic [3:0] ea;
      int di;
      if (rst) begin
         active   = 0;
         pend_cnt = 0;
         prev_nr  = 0;
      end else begin
         if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
               cur    = pend;
               active = 1;
               k      = 0;
            end
         end
         if (!in_ready) begin
            chk("ready_pulse", {31'd0, prev_nr}, 32'd0);
            if (q.size() == 0) begin
               chk("unexpected_load", 32'd1, 32'd0);
            end else begin
               pend     = q.pop_front();
               pend_cnt = 2;
            end
         end
         if (pend_cnt == 0) begin
            chk("dp", {31'd0, dp}, 32'd1);
            if (active) begin
               di = (k / DIV) % 4;
               ea = 4'b0001 << di;
               ea = ~ea;
               chk("an", {28'd0, an}, {28'd0, ea});
               chk("seg", {25'd0, seg}, {25'd0, cur.seg[di]});
               chk("ovf", {31'd0, ovf}, {31'd0, cur.ovf});
               k++;
            end else begin
               chk("idle_an", {28'd0, an}, 32'hF);
               chk("idle_seg", {25'd0, seg}, 32'h7F);
               chk("idle_ovf", {31'd0, ovf}, 32'd0);
               chk("idle_ready", {31'd0, in_ready}, 32'd1);
            end
         end
         prev_nr = !in_ready;
      end
   end

   task automatic send(input int unsigned v);
      bit ok = 0;
      bin      = WIDTH'(v);
      in_valid = 1'b1;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         chk("ready_timeout", 32'd0, 32'd1);
         in_valid = 1'b0;
      end else begin
         @(posedge clk);
         q.push_back(model(v));
         #1 in_valid = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; bin = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      idle(20);

      send(1234); idle(20);
      send(7);    idle(20);
      send(0);    idle(20);
      send(12000); idle(20);
      send(42);   idle(20);

      // Re-load while the hundreds digit is lit; a valid held into LOAD is dropped.
      send(1234); idle(11);
      send(56);
      bin = WIDTH'(999); in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      idle(20);

      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      idle(6);
      send(99); idle(20);

      for (int i = 0; i < 30; i++) begin
         int unsigned v;
         v = ($urandom % 4 == 0) ? $urandom_range(32767, 10000) : $urandom_range(9999, 0);
         send(v);
         idle($urandom_range(30, 0));
      end
      send(10000); idle(20);
      send(9999);  idle(20);

      chk("queue_drained", q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
